// File: rtl/icache_refill_axi_rd_if.sv
// ---------------------------------------------------------------------------
// icache_refill_axi_rd_if
// Bundle of the signals between the refill engine, the instruction cache and
// the AXI4 read channels (AR/R).
//   Cache side : rstart, raddr (to engine); rok, rdata, rbeat, rerr, busy
//                (from engine)
//   AR channel : arvalid, araddr, arid, arlen, arsize, arburst (from engine);
//                arready (to engine)
//   R channel  : rvalid, rdata_axi, rresp, rlast, rid (to engine);
//                rready (from engine)
// The master modport is the refill engine. The slave modport is the cache and
// interconnect side.
// ---------------------------------------------------------------------------
interface icache_refill_axi_rd_if;
    logic        rstart;
    logic [31:0] raddr;
    logic        rok;
    logic [31:0] rdata;
    logic [3:0]  rbeat;
    logic        rerr;
    logic        busy;

    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;

    logic        rvalid;
    logic        rready;
    logic [31:0] rdata_axi;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;

    modport master (
        input  rstart, raddr, arready, rvalid, rdata_axi, rresp, rlast, rid,
        output rok, rdata, rbeat, rerr, busy,
        output arvalid, araddr, arid, arlen, arsize, arburst, rready
    );

    modport slave (
        output rstart, raddr, arready, rvalid, rdata_axi, rresp, rlast, rid,
        input  rok, rdata, rbeat, rerr, busy,
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready
    );
endinterface

// File: rtl/icache_refill_axi_rd.sv
// ---------------------------------------------------------------------------
// icache_refill_axi_rd
// Refill engine for the instruction cache. A one-cycle rstart pulse issues a
// single line-aligned AXI4 INCR read burst of BURST_LEN 32-bit beats. Each
// accepted R beat is returned to the cache one cycle later as a one-cycle rok
// pulse. That pulse carries the registered data, the beat index and an error
// flag. Only one refill is in flight at a time.
// Ports:
//   i_clock : clock. All logic runs on the rising edge.
//   i_reset : synchronous reset, active high.
//   bus     : cache handshake plus the AXI AR/R channels (master modport).
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | no refill active. An rstart pulse latches the address.
// S_AR   | arvalid is held with a stable araddr until arready is seen.
// S_R    | rready is high. Each rvalid cycle is returned as one beat.
// S_DONE | the final rok is visible. busy is released on the next edge.
// ---------------------------------------------------------------------------
module icache_refill_axi_rd #(
    parameter int          BURST_LEN = 1,
    parameter logic [3:0]  AXI_ID    = 4'd0
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    icache_refill_axi_rd_if.master        bus
);
    localparam int          OFF_BITS   = $clog2(BURST_LEN * 4);
    localparam logic [31:0] ALIGN_MASK = ~((32'd1 << OFF_BITS) - 32'd1);
    localparam logic [3:0]  LAST_BEAT  = 4'(BURST_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_arvalid, w_arvalid_nxt;
    logic        r_rready, w_rready_nxt;
    logic [31:0] r_araddr, w_araddr_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic        r_rok, w_rok_nxt;
    logic [31:0] r_rdata, w_rdata_nxt;
    logic [3:0]  r_rbeat, w_rbeat_nxt;
    logic        r_rerr, w_rerr_nxt;

    logic        w_is_last;
    logic        w_beat_err;

    assign w_is_last  = (r_cnt == LAST_BEAT);
    // rlast is checked against the engine's own beat count. An early or
    // missing rlast is reported on that beat, and the count still ends the burst.
    assign w_beat_err = (bus.rresp != 2'b00) || (bus.rlast != w_is_last) ||
                        (bus.rid != AXI_ID);

    always_comb begin
        w_state_nxt   = r_state;
        w_busy_nxt    = r_busy;
        w_arvalid_nxt = r_arvalid;
        w_rready_nxt  = r_rready;
        w_araddr_nxt  = r_araddr;
        w_cnt_nxt     = r_cnt;
        w_rok_nxt     = 1'b0;
        w_rdata_nxt   = r_rdata;
        w_rbeat_nxt   = r_rbeat;
        w_rerr_nxt    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.rstart) begin
                    w_araddr_nxt  = bus.raddr & ALIGN_MASK;
                    w_busy_nxt    = 1'b1;
                    w_arvalid_nxt = 1'b1;
                    w_state_nxt   = S_AR;
                end
            end
            S_AR: begin
                if (bus.arready) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_cnt_nxt     = 4'd0;
                    w_state_nxt   = S_R;
                end
            end
            S_R: begin
                if (bus.rvalid) begin
                    w_rok_nxt   = 1'b1;
                    w_rdata_nxt = bus.rdata_axi;
                    w_rbeat_nxt = r_cnt;
                    w_rerr_nxt  = w_beat_err;
                    if (w_is_last) begin
                        w_rready_nxt = 1'b0;
                        w_state_nxt  = S_DONE;
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
            end
            S_DONE: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_araddr  <= 32'd0;
            r_cnt     <= 4'd0;
            r_rok     <= 1'b0;
            r_rdata   <= 32'd0;
            r_rbeat   <= 4'd0;
            r_rerr    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_busy    <= w_busy_nxt;
            r_arvalid <= w_arvalid_nxt;
            r_rready  <= w_rready_nxt;
            r_araddr  <= w_araddr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rok     <= w_rok_nxt;
            r_rdata   <= w_rdata_nxt;
            r_rbeat   <= w_rbeat_nxt;
            r_rerr    <= w_rerr_nxt;
        end
    end

    assign bus.rok     = r_rok;
    assign bus.rdata   = r_rdata;
    assign bus.rbeat   = r_rbeat;
    assign bus.rerr    = r_rerr;
    assign bus.busy    = r_busy;
    assign bus.arvalid = r_arvalid;
    assign bus.araddr  = r_araddr;
    assign bus.rready  = r_rready;
    assign bus.arid    = AXI_ID;
    assign bus.arlen   = 8'(BURST_LEN - 1);
    assign bus.arsize  = 3'b010;
    assign bus.arburst = 2'b01;
endmodule

// File: tb/tb_icache_refill_axi_rd.sv
// ---------------------------------------------------------------------------
// tb_icache_refill_axi_rd
// Bench for the refill engine. It instantiates one engine with BURST_LEN=1 and
// AXI_ID=5, and one with BURST_LEN=4 and AXI_ID=0. Both share the clock and
// the reset.
// ---------------------------------------------------------------------------
module tb_icache_refill_axi_rd;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    icache_refill_axi_rd_if if1 ();
    icache_refill_axi_rd_if if4 ();

    icache_refill_axi_rd #(.BURST_LEN(1), .AXI_ID(4'd5)) dut1 (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (if1.master)
    );

    icache_refill_axi_rd #(.BURST_LEN(4), .AXI_ID(4'd0)) dut4 (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (if4.master)
    );

    typedef struct {
        logic        st;
        logic [31:0] ad;
        logic        ar;
        logic        rv;
        logic [31:0] d;
        logic [1:0]  rr;
        logic        rl;
        logic [3:0]  id;
        logic        e_rok;
        logic [31:0] e_d;
        logic [3:0]  e_b;
        logic        e_err;
        logic        e_busy;
        logic        e_arv;
        logic        e_rrdy;
        logic [31:0] e_ad;
    } vec_t;

    vec_t vt[28];

    function automatic vec_t v(input logic [31:0] st, ad, ar, rv, d, rr, rl, id,
                               e_rok, e_d, e_b, e_err, e_busy, e_arv, e_rrdy, e_ad);
        vec_t r;
        r.st = st[0]; r.ad = ad; r.ar = ar[0]; r.rv = rv[0]; r.d = d;
        r.rr = rr[1:0]; r.rl = rl[0]; r.id = id[3:0];
        r.e_rok = e_rok[0]; r.e_d = e_d; r.e_b = e_b[3:0]; r.e_err = e_err[0];
        r.e_busy = e_busy[0]; r.e_arv = e_arv[0]; r.e_rrdy = e_rrdy[0]; r.e_ad = e_ad;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if1.rstart = 0; if1.raddr = 0; if1.arready = 0; if1.rvalid = 0;
        if1.rdata_axi = 0; if1.rresp = 0; if1.rlast = 0; if1.rid = 0;
        if4.rstart = 0; if4.raddr = 0; if4.arready = 0; if4.rvalid = 0;
        if4.rdata_axi = 0; if4.rresp = 0; if4.rlast = 0; if4.rid = 0;
    endtask

    task automatic chk4_zero(input string tag);
        chk({tag, " rok"},     32'(if4.rok),     0);
        chk({tag, " rdata"},   if4.rdata,        0);
        chk({tag, " rbeat"},   32'(if4.rbeat),   0);
        chk({tag, " rerr"},    32'(if4.rerr),    0);
        chk({tag, " busy"},    32'(if4.busy),    0);
        chk({tag, " arvalid"}, 32'(if4.arvalid), 0);
        chk({tag, " rready"},  32'(if4.rready),  0);
        chk({tag, " araddr"},  if4.araddr,       0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = v(1, 'h8000001C, 0, 0, 0,     0, 0, 0,  0, 0,     0, 0,  1, 1, 0, 'h80000010);
        vt[1]  = v(0, 0,          0, 0, 0,     0, 0, 0,  0, 0,     0, 0,  1, 1, 0, 'h80000010);
        vt[2]  = v(0, 0,          0, 0, 0,     0, 0, 0,  0, 0,     0, 0,  1, 1, 0, 'h80000010);
        vt[3]  = v(0, 0,          1, 0, 0,     0, 0, 0,  0, 0,     0, 0,  1, 0, 1, 0);
        vt[4]  = v(0, 0,          0, 1, 'h11,  0, 0, 0,  1, 'h11,  0, 0,  1, 0, 1, 0);
        vt[5]  = v(0, 0,          0, 0, 0,     0, 0, 0,  0, 0,     0, 0,  1, 0, 1, 0);
        vt[6]  = v(0, 0,          0, 1, 'h22,  0, 0, 0,  1, 'h22,  1, 0,  1, 0, 1, 0);
        vt[7]  = v(0, 0,          0, 0, 0,     0, 0, 0,  0, 0,     0, 0,  1, 0, 1, 0);
        vt[8]  = v(0, 0,          0, 0, 0,     0, 0, 0,  0, 0,     0, 0,  1, 0, 1, 0);
        vt[9]  = v(0, 0,          0, 1, 'h33,  0, 0, 0,  1, 'h33,  2, 0,  1, 0, 1, 0);
        vt[10] = v(0, 0,          0, 1, 'h44,  0, 1, 0,  1, 'h44,  3, 0,  1, 0, 0, 0);
        vt[11] = v(0, 0,          0, 0, 0,     0, 0, 0,  0, 0,     0, 0,  0, 0, 0, 0);
        vt[12] = v(0, 0,          0, 1, 'h99,  0, 1, 0,  0, 0,     0, 0,  0, 0, 0, 0);
        vt[13] = v(1, 'h80000040, 0, 0, 0,     0, 0, 0,  0, 0,     0, 0,  1, 1, 0, 'h80000040);
        vt[14] = v(0, 0,          1, 1, 'h55,  0, 0, 0,  0, 0,     0, 0,  1, 0, 1, 0);
        vt[15] = v(0, 0,          0, 1, 'hA0,  0, 0, 0,  1, 'hA0,  0, 0,  1, 0, 1, 0);
        vt[16] = v(0, 0,          0, 1, 'hA1,  0, 0, 4,  1, 'hA1,  1, 1,  1, 0, 1, 0);
        vt[17] = v(0, 0,          0, 1, 'hA2,  2, 0, 0,  1, 'hA2,  2, 1,  1, 0, 1, 0);
        vt[18] = v(0, 0,          0, 1, 'hA3,  0, 1, 0,  1, 'hA3,  3, 0,  1, 0, 0, 0);
        vt[19] = v(1, 'h12345678, 0, 0, 0,     0, 0, 0,  0, 0,     0, 0,  0, 0, 0, 0);
        vt[20] = v(0, 0,          0, 0, 0,     0, 0, 0,  0, 0,     0, 0,  0, 0, 0, 0);
        vt[21] = v(1, 'h00000104, 0, 0, 0,     0, 0, 0,  0, 0,     0, 0,  1, 1, 0, 'h00000100);
        vt[22] = v(0, 0,          1, 0, 0,     0, 0, 0,  0, 0,     0, 0,  1, 0, 1, 0);
        vt[23] = v(0, 0,          0, 1, 1,     0, 0, 0,  1, 1,     0, 0,  1, 0, 1, 0);
        vt[24] = v(0, 0,          0, 1, 2,     0, 1, 0,  1, 2,     1, 1,  1, 0, 1, 0);
        vt[25] = v(1, 'h00000200, 0, 1, 3,     0, 0, 0,  1, 3,     2, 0,  1, 0, 1, 0);
        vt[26] = v(0, 0,          0, 1, 4,     0, 0, 0,  1, 4,     3, 1,  1, 0, 0, 0);
        vt[27] = v(0, 0,          0, 0, 0,     0, 0, 0,  0, 0,     0, 0,  0, 0, 0, 0);

        idle_inputs();
        rst = 1;
        tick();
        tick();
        chk4_zero("reset");
        chk("reset1 busy",    32'(if1.busy),    0);
        chk("reset1 arvalid", 32'(if1.arvalid), 0);
        chk("reset1 rok",     32'(if1.rok),     0);

        // A request that arrives together with reset is dropped.
        if4.rstart = 1; if4.raddr = 32'h0000_0400;
        tick();
        rst = 0; if4.rstart = 0;
        tick();
        chk("rst+rstart busy",    32'(if4.busy),    0);
        chk("rst+rstart arvalid", 32'(if4.arvalid), 0);

        chk("const4 arlen",   32'(if4.arlen),   3);
        chk("const4 arsize",  32'(if4.arsize),  2);
        chk("const4 arburst", 32'(if4.arburst), 1);
        chk("const4 arid",    32'(if4.arid),    0);

        // BURST_LEN=1 single-beat refill.
        if1.rstart = 1; if1.raddr = 32'h8000_0006; if1.arready = 1;
        tick();
        chk("b1 arvalid", 32'(if1.arvalid), 1);
        chk("b1 araddr",  if1.araddr,       32'h8000_0004);
        chk("b1 busy",    32'(if1.busy),    1);
        chk("b1 arlen",   32'(if1.arlen),   0);
        chk("b1 arid",    32'(if1.arid),    5);
        if1.rstart = 0; if1.raddr = 0;
        tick();
        chk("b1 arvalid drop", 32'(if1.arvalid), 0);
        chk("b1 rready",       32'(if1.rready),  1);
        if1.arready = 0;
        if1.rvalid = 1; if1.rdata_axi = 32'hDEAD_BEEF; if1.rlast = 1; if1.rid = 5;
        tick();
        chk("b1 rok",    32'(if1.rok),    1);
        chk("b1 rdata",  if1.rdata,       32'hDEAD_BEEF);
        chk("b1 rbeat",  32'(if1.rbeat),  0);
        chk("b1 rerr",   32'(if1.rerr),   0);
        chk("b1 busy@rok", 32'(if1.busy), 1);
        chk("b1 rready off", 32'(if1.rready), 0);
        if1.rvalid = 0; if1.rlast = 0; if1.rid = 0;
        tick();
        chk("b1 rok end",  32'(if1.rok),  0);
        chk("b1 busy end", 32'(if1.busy), 0);

        // Cycle-by-cycle vectors for the BURST_LEN=4 engine.
        for (int i = 0; i < 28; i++) begin
            if4.rstart = vt[i].st; if4.raddr = vt[i].ad; if4.arready = vt[i].ar;
            if4.rvalid = vt[i].rv; if4.rdata_axi = vt[i].d; if4.rresp = vt[i].rr;
            if4.rlast = vt[i].rl; if4.rid = vt[i].id;
            tick();
            chk($sformatf("v%0d rok", i),     32'(if4.rok),     32'(vt[i].e_rok));
            chk($sformatf("v%0d busy", i),    32'(if4.busy),    32'(vt[i].e_busy));
            chk($sformatf("v%0d arvalid", i), 32'(if4.arvalid), 32'(vt[i].e_arv));
            chk($sformatf("v%0d rready", i),  32'(if4.rready),  32'(vt[i].e_rrdy));
            if (vt[i].e_arv) chk($sformatf("v%0d araddr", i), if4.araddr, vt[i].e_ad);
            if (vt[i].e_rok) begin
                chk($sformatf("v%0d rdata", i), if4.rdata,       vt[i].e_d);
                chk($sformatf("v%0d rbeat", i), 32'(if4.rbeat),  32'(vt[i].e_b));
                chk($sformatf("v%0d rerr", i),  32'(if4.rerr),   32'(vt[i].e_err));
            end
        end
        idle_inputs();

        // Reset in the middle of a burst, followed by a clean refill.
        if4.rstart = 1; if4.raddr = 32'h0000_0080;
        tick();
        if4.rstart = 0; if4.arready = 1;
        tick();
        if4.arready = 0;
        if4.rvalid = 1; if4.rdata_axi = 32'h1;
        tick();
        if4.rdata_axi = 32'h2;
        tick();
        chk("mid rbeat before reset", 32'(if4.rbeat), 1);
        if4.rvalid = 0; if4.rdata_axi = 0;
        rst = 1;
        tick();
        rst = 0;
        chk4_zero("mid-reset");
        tick();
        chk("post-reset rready", 32'(if4.rready), 0);

        if4.rstart = 1; if4.raddr = 32'h0000_030C;
        tick();
        if4.rstart = 0;
        chk("fresh araddr", if4.araddr, 32'h0000_0300);
        if4.arready = 1;
        tick();
        if4.arready = 0;
        for (int b = 0; b < 4; b++) begin
            if4.rvalid = 1; if4.rdata_axi = 32'hC0 + 32'(b); if4.rlast = (b == 3);
            tick();
            chk($sformatf("fresh b%0d rok", b),   32'(if4.rok),   1);
            chk($sformatf("fresh b%0d rbeat", b), 32'(if4.rbeat), 32'(b));
            chk($sformatf("fresh b%0d rdata", b), if4.rdata,      32'hC0 + 32'(b));
            chk($sformatf("fresh b%0d rerr", b),  32'(if4.rerr),  0);
            if4.rvalid = 0; if4.rlast = 0;
            if (b != 3) begin
                tick();
                chk($sformatf("fresh gap%0d rok", b), 32'(if4.rok), 0);
            end
        end
        chk("fresh busy@last", 32'(if4.busy), 1);
        tick();
        chk("fresh busy end", 32'(if4.busy), 0);
        chk("fresh rok end",  32'(if4.rok),  0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/icache_refill_axi_rd.md
Name: icache_refill_axi_rd

Overview:
- Memory-side refill engine directly downstream of the instruction cache.
- Receives a one-cycle `rstart` miss pulse plus miss address and issues an AXI4 INCR read burst (32-bit data) on AR/R.
- Returns each beat to the cache as a one-cycle `rok` pulse with registered `rdata`.
- Only one refill is outstanding at a time. Bus errors and protocol violations are flagged, never hidden.

Parameters:
- `BURST_LEN`, 1, beats per refill (1, 2, 4, 8 or 16); equals cache block size in 32-bit words.
- `AXI_ID`, 0, 4-bit constant driven on `arid`.

Ports:
- `clock` input 1 — single clock; all logic on posedge.
- `reset` input 1 — synchronous, active-high.
- `rstart` input 1 — one-cycle refill request from cache.
- `raddr` input 32 — miss address, sampled with `rstart`.
- `rok` output 1 — one-cycle pulse, `rdata`/`rbeat`/`rerr` valid.
- `rdata` output 32 — refill beat data, registered.
- `rbeat` output 4 — beat index 0..`BURST_LEN`-1 of current `rok`.
- `rerr` output 1 — qualifies `rok`: `rresp`≠OKAY, or `rlast` mismatch on this beat.
- `busy` output 1 — high from accepted `rstart` until final `rok` cycle inclusive.
- `arvalid` output 1, `arready` input 1, `araddr` output 32, `arid` output 4, `arlen` output 8, `arsize` output 3, `arburst` output 2 — AXI4 AR channel.
- `rvalid` input 1, `rready` output 1, `rdata_axi` input 32, `rresp` input 2, `rlast` input 1, `rid` input 4 — AXI4 R channel.

Behaviour:
- Reset values: `rok`=0, `rdata`=0, `rbeat`=0, `rerr`=0, `busy`=0, `arvalid`=0, `rready`=0, `araddr`=0. State returns to IDLE.
- Constant outputs: `arid`=`AXI_ID`, `arlen`=`BURST_LEN`-1, `arsize`=3'b010, `arburst`=2'b01 (INCR).
- `araddr` = `raddr` with low log2(`BURST_LEN`*4) bits cleared, i.e. line-aligned; latched on accept.
- FSM states: IDLE, AR, R, DONE.
  - IDLE: on `rstart`, latch address, set `busy`=1 and `arvalid`=1 → AR. Cycle N `rstart` gives `arvalid` high at N+1.
  - AR: hold `arvalid` and `araddr` stable until `arvalid`&`arready`. On that edge `arvalid`→0, `rready`→1, beat counter=0 → R.
  - R: `rready` held high. Each `rvalid` cycle is a beat handshake: capture `rdata_axi` into `rdata`, `rbeat`=counter, `rok`=1 on the next cycle (1-cycle latency), then counter+1.
  - R, per-beat `rerr`=1 if: `rresp`≠0, or `rlast`≠(counter==`BURST_LEN`-1), or `rid`≠`AXI_ID`.
  - R, final beat: when counter==`BURST_LEN`-1 handshakes, `rready`→0 → DONE.
  - DONE: final `rok` is high this cycle; `busy`=1 this cycle, `busy`=0 next. → IDLE.
- Early `rlast`: still only counter==`BURST_LEN`-1 ends the burst. The beat gets `rerr`=1 and the engine waits for the remaining beats.
- `rok` is never high on two consecutive cycles unless consecutive R beats arrive. There is no backpressure from the cache; it must absorb every `rok`.
- `rstart` while `busy`=1 (including the DONE cycle) is ignored; no queueing.
- `rstart` in the same cycle as reset: reset wins and the request is dropped.
- Reset mid-burst: immediate return to IDLE, outputs forced to reset values. The interconnect shares this reset, so no orphan beats return.
- `rvalid` seen in IDLE or AR is an unexpected beat: `rready` is low so it is not accepted, and no `rok` is generated.
- Counter width is 4 bits; `BURST_LEN`=16 uses 0..15 with no wrap past 15.

Test Plan:
- `BURST_LEN`=1, `rstart` with `raddr`=0x8000_0006, `arready`=1 immediately, R beat 0xDEADBEEF `rlast`=1 two cycles later → `araddr`=0x8000_0004, `arlen`=0, single `rok` with `rdata`=0xDEADBEEF, `rbeat`=0, `rerr`=0, `busy` drops the cycle after.
- `BURST_LEN`=4, `raddr`=0x8000_001C, `arready` delayed 3 cycles, beats 0x11,0x22,0x33,0x44 with gaps → `araddr`=0x8000_0010 held stable while waiting, `arlen`=3, four `rok` pulses with `rbeat` 0..3 and matching data.
- `BURST_LEN`=4, beat 2 with `rresp`=2'b10 → that `rok` has `rerr`=1; other beats have `rerr`=0; burst completes normally.
- `BURST_LEN`=4, `rlast`=1 on beat 1 → beat 1 `rerr`=1; engine still accepts beats 2 and 3, with `rerr`=1 on beat 3 (`rlast`=0).
- Second `rstart` during R → ignored; exactly `BURST_LEN` `rok` pulses; then a new `rstart` after `busy`=0 is accepted.
- Reset asserted in R after beat 1 → next cycle all outputs are 0 and state is IDLE; a fresh `rstart` then runs a full burst correctly.
